// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period monitor.
// Holds the measurement FSM state type and the default counter width and
// synchronizer depth used by clk_period_monitor and its interface.
package clk_meas_pkg;

  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefSyncStages = 2;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas
  } meas_state_e;

endpackage

// File: rtl/clk_period_monitor_if.sv
// Signal bundle between a pulse-train source/consumer and clk_period_monitor.
//   sig_in, enable               : stimulus side -> monitor
//   period, high_time, duty50    : last completed measurement (held)
//   meas_valid, timeout          : one-cycle event pulses
// Modport master is the stimulus/consumer side, slave is the monitor.
interface clk_period_monitor_if
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
);

  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             duty50;
  logic             timeout;

  modport master (
    output sig_in,
    output enable,
    input  period,
    input  high_time,
    input  meas_valid,
    input  duty50,
    input  timeout
  );

  modport slave (
    input  sig_in,
    input  enable,
    output period,
    output high_time,
    output meas_valid,
    output duty50,
    output timeout
  );

endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into the clk domain and flags its edges.
//   clk, reset : system clock, asynchronous active-high reset
//   sig_in     : asynchronous input
//   s          : synchronized level
//   rdet, fdet : single-cycle rising / falling edge of s
// Edges are only reported once the previous value of s came from a real
// post-reset sample, so an input already high at reset release does not
// produce a spurious rising edge before s has been seen low.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic s,
  output logic rdet,
  output logic fdet
);

  logic [SYNC_STAGES-1:0] sync_q;
  // Marks which pipeline positions hold real samples; the extra top bit
  // covers prev_q.
  logic [SYNC_STAGES:0]   vld_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rdet = vld_q[SYNC_STAGES] & s & ~prev_q;
  assign fdet = vld_q[SYNC_STAGES] & ~s & prev_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of a slow pulse train in clk cycles.
//   clk, reset : system clock, asynchronous active-high reset
//   mon        : slave side of clk_period_monitor_if (sig_in/enable in,
//                period/high_time/duty50/meas_valid/timeout out)
// A measurement window runs from one rising edge of the synchronized input
// to the next. Counters saturate at all-ones; reaching that without an edge
// reports timeout and re-arms. Results only change on meas_valid.
module clk_period_monitor
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input logic                 clk,
  input logic                 reset,
  clk_period_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic s, rdet, fdet;
  logic enable, cnt_max;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             duty_q, duty_d, valid_q, valid_d, tmo_q, tmo_d;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .sig_in(mon.sig_in),
    .s     (s),
    .rdet  (rdet),
    .fdet  (fdet)
  );

  assign enable  = mon.enable;
  assign cnt_max = (cnt_q == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StArm;
      StArm:   if (rdet) state_d = StMeas;
      StMeas:  if (!rdet && cnt_max) state_d = StArm;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  always_comb begin
    cnt_d    = '0;
    hcnt_d   = '0;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;
    if (enable) begin
      unique case (state_q)
        StArm: begin
          // The edge cycle is the first cycle of the window and s is high.
          if (rdet) begin
            cnt_d  = CntOne;
            hcnt_d = CntOne;
          end
        end
        StMeas: begin
          if (rdet) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            duty_d   = ({hcnt_q, 1'b0} == {1'b0, cnt_q});
            valid_d  = 1'b1;
            cnt_d    = CntOne;
            hcnt_d   = CntOne;
          end else if (cnt_max) begin
            tmo_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + CntOne;
            hcnt_d = hcnt_q + CNT_W'(s);
          end
        end
        default: ;
      endcase
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_q;
  assign mon.duty50     = duty_q;
  assign mon.meas_valid = valid_q;
  assign mon.timeout    = tmo_q;

  edges_exclusive: assert property (@(posedge clk) disable iff (reset) !(rdet && fdet));
  events_exclusive: assert property (@(posedge clk) disable iff (reset) !(valid_q && tmo_q));

endmodule

// File: tb/tb_clk_period_monitor.sv
module tb_clk_period_monitor;

  localparam int unsigned CntW    = 8;
  localparam int unsigned Stages  = 3;
  localparam int          MaxCnt  = (1 << CntW) - 1;
  localparam int          HistLen = 16384;

  typedef struct {
    int cyc;
    bit is_tmo;
    int per;
    int hi;
    bit d50;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clk_period_monitor_if #(.CNT_W(CntW)) mon ();

  clk_period_monitor #(
    .CNT_W      (CntW),
    .SYNC_STAGES(Stages)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (mon)
  );

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: input history, reset release point, window anchor.
  bit  x_hist [HistLen];
  int  rel_cyc = HistLen;
  int  run_start = -1;
  int  anchor = -1;
  ev_t exp_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  hold_per = 0;
  int  hold_hi = 0;
  int  hold_d50 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronized level the monitor sees in cycle n, and whether it is a
  // genuine post-reset sample.
  function automatic bit valid_at(input int n);
    return (n - int'(Stages)) >= rel_cyc;
  endfunction

  function automatic bit s_at(input int n);
    if (!valid_at(n)) return 1'b0;
    return x_hist[n - int'(Stages)];
  endfunction

  task automatic model_cycle(input int n, input bit en);
    bit  rd;
    int  hi;
    ev_t e;
    rd = valid_at(n - 1) && s_at(n) && !s_at(n - 1);
    if (!en) begin
      run_start = -1;
      anchor    = -1;
      return;
    end
    if (run_start < 0) begin
      run_start = n;
      return;
    end
    if (anchor >= 0 && !rd && (n - anchor) == MaxCnt) begin
      e = '{cyc: n + 1, is_tmo: 1'b1, per: 0, hi: 0, d50: 1'b0};
      exp_q.push_back(e);
      anchor = -1;
    end else if (rd) begin
      if (anchor >= 0) begin
        hi = 0;
        for (int k = anchor; k < n; k++) hi += int'(s_at(k));
        e = '{cyc: n + 1, is_tmo: 1'b0, per: n - anchor, hi: hi, d50: (2 * hi == n - anchor)};
        exp_q.push_back(e);
      end
      anchor = n;
    end
  endtask

  task automatic step(input bit x, input bit en);
    @(posedge clk);
    #1;
    mon.sig_in = x;
    mon.enable = en;
    if (cyc < HistLen) x_hist[cyc] = x;
    if (!reset) model_cycle(cyc, en);
  endtask

  task automatic pulse_train(input int hi, input int lo, input int reps, input bit en);
    for (int r = 0; r < reps; r++) begin
      repeat (hi) step(1'b1, en);
      repeat (lo) step(1'b0, en);
    end
  endtask

  task automatic do_reset(input int ncyc, input bit x, input bit en);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon.sig_in = x;
    mon.enable = en;
    while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    run_start = -1;
    anchor    = -1;
    repeat (ncyc) @(posedge clk);
    #1;
    reset   = 1'b0;
    rel_cyc = cyc;
    x_hist[cyc] = x;
    model_cycle(cyc, en);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      hold_per = 0;
      hold_hi  = 0;
      hold_d50 = 0;
      check("reset_period", int'(mon.period), 0);
      check("reset_high_time", int'(mon.high_time), 0);
      check("reset_flags", int'({mon.duty50, mon.meas_valid, mon.timeout}), 0);
    end else begin
      if (mon.meas_valid && mon.timeout) check("valid_timeout_exclusive", 1, 0);
      if (mon.meas_valid || mon.timeout) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_cycle", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_is_timeout", int'(mon.timeout), int'(e.is_tmo));
          if (!e.is_tmo) begin
            hold_per = e.per;
            hold_hi  = e.hi;
            hold_d50 = int'(e.d50);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missing_event_at_cycle", -1, e.cyc);
      end
      check("period", int'(mon.period), hold_per);
      check("high_time", int'(mon.high_time), hold_hi);
      check("duty50", int'(mon.duty50), hold_d50);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit x;
    int len;
    mon.sig_in = 1'b0;
    mon.enable = 1'b0;
    do_reset(3, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    // Divide-by-2, then 3 high / 2 low.
    pulse_train(1, 1, 20, 1'b1);
    pulse_train(3, 2, 12, 1'b1);
    repeat (25) pulse_train(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1, 1'b1);
    // One edge then held low: timeout, then recovery.
    pulse_train(5, 5, 2, 1'b1);
    repeat (300) step(1'b0, 1'b1);
    pulse_train(4, 4, 3, 1'b1);
    // Longest measurable period, then one cycle too long.
    pulse_train(100, 155, 3, 1'b1);
    pulse_train(100, 156, 2, 1'b1);
    pulse_train(6, 6, 2, 1'b1);
    // Enable dropped mid-period.
    pulse_train(6, 6, 3, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    pulse_train(6, 6, 3, 1'b1);
    // Reset mid-measurement with input high across release.
    pulse_train(7, 3, 2, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    do_reset(3, 1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    pulse_train(2, 3, 5, 1'b1);
    // Random run lengths with occasional enable drops.
    x = 1'b0;
    repeat (80) begin
      len = int'($urandom_range(1, 9));
      x = ~x;
      repeat (len) step(x, $urandom_range(0, 15) != 0);
    end
    repeat (12) step(1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
